// File: rtl/led_scan_pkg.sv
// Shared types for the LED scanner family: mode encodings, scan direction,
// and the position-width helper.
package led_scan_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_ROT_L  = 2'b01,
    MODE_ROT_R  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int unsigned pos_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_scanner_strobe_gen.sv
// strobe_gen: divides clk by CLK_HZ/STEP_HZ while en is high; strobe is a
// combinational one-cycle flag on the last count, so callers update on the wrap edge.
module strobe_gen #(
  parameter int unsigned CLK_HZ  = 27000000,
  parameter int unsigned STEP_HZ = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic strobe
);

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_div_check
    $error("strobe_gen: CLK_HZ/STEP_HZ must be at least 1");
  end

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= strobe ? '0 : count + 1'b1;
    end
  end

  assign strobe = en && (count == LAST);

endmodule

// File: rtl/led_scanner.sv
// led_scanner: single lit LED stepping across an N-LED bar (bounce/rotate/hold).
// Define LED_SCANNER_TRAIL_EN to add a 25%-duty comet tail on the previous position.
module led_scanner
  import led_scan_pkg::*;
#(
  parameter int unsigned N_LEDS     = 6,
  parameter int unsigned CLK_HZ     = 27000000,
  parameter int unsigned STEP_HZ    = 16,
  parameter bit          ACTIVE_LOW = 1'b1,
  localparam int unsigned PW        = pos_width(N_LEDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led,
  output logic [PW-1:0]     pos,
  output logic              step
);

  localparam logic [PW-1:0]     LAST    = PW'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] POL     = ACTIVE_LOW ? '1 : '0;
  localparam logic [N_LEDS-1:0] LED_RST = POL ^ N_LEDS'(1);

  if (N_LEDS < 1 || N_LEDS > 32) begin : g_n_check
    $error("led_scanner: N_LEDS must be in 1..32");
  end

  logic              tick;
  logic [PW-1:0]     pos_d;
  dir_e              dir_q, dir_d;
  logic              go_up;
  logic [N_LEDS-1:0] head, led_d;
`ifdef LED_SCANNER_TRAIL_EN
  logic [PW-1:0]     trail_q, trail_d;
  logic [1:0]        pwm_q, pwm_d;
  logic [N_LEDS-1:0] tail;
`endif

  strobe_gen #(
    .CLK_HZ (CLK_HZ),
    .STEP_HZ(STEP_HZ)
  ) u_strobe (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .strobe(tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos   <= '0;
      dir_q <= DIR_UP;
      step  <= 1'b0;
      led   <= LED_RST;
`ifdef LED_SCANNER_TRAIL_EN
      trail_q <= '0;
      pwm_q   <= '0;
`endif
    end else begin
      pos   <= pos_d;
      dir_q <= dir_d;
      step  <= tick;
      led   <= led_d;
`ifdef LED_SCANNER_TRAIL_EN
      trail_q <= trail_d;
      pwm_q   <= pwm_d;
`endif
    end
  end

  always_comb begin
    pos_d = pos;
    dir_d = dir_q;
    go_up = 1'b0;
    if (tick && N_LEDS > 1) begin
      unique case (mode_e'(mode))
        MODE_BOUNCE: begin
          // An outward-pointing dir at an endpoint (left by a rotate) reflects before moving.
          go_up = (dir_q == DIR_UP) ? (pos != LAST) : (pos == '0);
          pos_d = go_up ? pos + 1'b1 : pos - 1'b1;
          if (pos_d == LAST)     dir_d = DIR_DOWN;
          else if (pos_d == '0)  dir_d = DIR_UP;
          else                   dir_d = go_up ? DIR_UP : DIR_DOWN;
        end
        MODE_ROT_L: begin
          pos_d = (pos == LAST) ? '0 : pos + 1'b1;
          dir_d = DIR_UP;
        end
        MODE_ROT_R: begin
          pos_d = (pos == '0) ? LAST : pos - 1'b1;
          dir_d = DIR_DOWN;
        end
        MODE_HOLD: begin
        end
      endcase
    end
  end

`ifdef LED_SCANNER_TRAIL_EN
  // In hold, pos_d equals pos, so the tail collapses onto the head.
  assign trail_d = tick ? pos : trail_q;
  assign pwm_d   = pwm_q + 1'b1;
`endif

  always_comb begin
    head = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) head[i] = (pos_d == PW'(i));
`ifdef LED_SCANNER_TRAIL_EN
    tail = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) tail[i] = (trail_d == PW'(i)) && (pwm_d == '0);
    led_d = (head | tail) ^ POL;
`else
    led_d = head ^ POL;
`endif
  end

endmodule
